// File: rtl/qif_syn_drive_8b.sv
// qif_syn_drive_8b: spike-event FIFO feeding a saturating, exponentially decaying synaptic current
module qif_syn_drive_8b #(
  parameter int DECAY_PERIOD = 16,
  parameter int DECAY_SHIFT = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              spike_valid,
  input  logic signed [7:0] spike_weight,
  output logic              spike_ready,
  output logic signed [7:0] I_syn,
  output logic              active,
  output logic              sat
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(DECAY_PERIOD);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic signed [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count, cnt_nxt;
  logic [PW-1:0] presc;
  logic push, pop, tick, go_idle, hi, lo;
  logic signed [7:0] shr, d, nxt, head;
  logic signed [9:0] i_ext, d_ext, w_ext, base, sum;
  always_comb begin
    count = wr_ptr - rd_ptr;
    spike_ready = count != (AW+1)'(FIFO_DEPTH);
    push = spike_valid & spike_ready;
    pop = en & (count != '0);
    cnt_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
    tick = (state == ACTIVE) & en & (presc == PW'(DECAY_PERIOD - 1));
    // positive values always shrink by at least 1 so decay reaches exactly 0
    shr = I_syn >>> DECAY_SHIFT;
    d = (I_syn > 8'sd0 && shr == 8'sd0) ? 8'sd1 : shr;
    head = mem[rd_ptr[AW-1:0]];
    i_ext = {{2{I_syn[7]}}, I_syn};
    d_ext = {{2{d[7]}}, d};
    w_ext = pop ? {{2{head[7]}}, head} : 10'sd0;
    base = tick ? i_ext - d_ext : i_ext;
    sum = base + w_ext;
    hi = sum > 10'sd127;
    lo = sum < -10'sd128;
    nxt = hi ? 8'sd127 : lo ? -8'sd128 : sum[7:0];
    go_idle = (state == ACTIVE) && (nxt == 8'sd0) && (cnt_nxt == '0);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= spike_weight;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      presc <= '0;
      I_syn <= '0;
      active <= 1'b0;
      sat <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      I_syn <= nxt;
      sat <= hi | lo;
      presc <= (go_idle || tick) ? '0 : (state == ACTIVE && en) ? presc + 1'b1 : presc;
      state <= (state == IDLE) ? (push ? ACTIVE : IDLE) : (go_idle ? IDLE : ACTIVE);
      active <= (state == IDLE) ? push : !go_idle;
    end
endmodule
